// File: rtl/idli_pkg.sv
// -----------------------------------------------------------------------------
// idli_pkg
// Shared types and constants for the idli core slice.
//   uart_tx_state_t : serialiser states of the UART transmitter.
//   UART_FRAME_BITS : bits per 8N1 frame (start + 8 data + stop).
//   UART_DATA_BITS  : data bits per frame.
// -----------------------------------------------------------------------------
package idli_pkg;

    typedef enum logic [1:0] {
        UART_TX_IDLE  = 2'd0,
        UART_TX_START = 2'd1,
        UART_TX_DATA  = 2'd2,
        UART_TX_STOP  = 2'd3
    } uart_tx_state_t;

    localparam int unsigned UART_FRAME_BITS = 10;
    localparam int unsigned UART_DATA_BITS  = UART_FRAME_BITS - 2;

endpackage

// File: rtl/idli_fifo_chk_m.sv
// -----------------------------------------------------------------------------
// idli_fifo_chk_m
// Simulation-only protocol checker for idli_fifo_m.
//   clk, rst_n : clock and asynchronous active-low reset of the FIFO.
//   push, pop  : FIFO request strobes.
//   full, empty: FIFO status.
// A push into a full FIFO without a simultaneous pop, or a pop from an empty
// FIFO, means the producer/consumer handshake upstream is broken.
// -----------------------------------------------------------------------------
module idli_fifo_chk_m (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input logic full,
    input logic empty
);

    no_overflow_a: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && full && !pop)
    );

    no_underflow_a: assert property (
        @(posedge clk) disable iff (!rst_n) !(pop && empty)
    );

endmodule

// File: rtl/idli_fifo_m.sv
// -----------------------------------------------------------------------------
// idli_fifo_m
// Generic synchronous circular-buffer FIFO with explicit occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset.
//   srst       : synchronous clear (empties the FIFO).
//   push       : write push_data at the tail this cycle.
//   push_data  : WIDTH-bit write data.
//   pop        : remove the head this cycle.
//   head       : current head entry (valid while !empty).
//   count      : occupancy, $clog2(DEPTH)+1 bits.
//   full/empty : status derived from count.
// DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
// Push and pop in the same cycle are legal even when full.
// -----------------------------------------------------------------------------
module idli_fifo_m #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         srst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             empty_s;
    logic             wr_en_s;
    logic             rd_en_s;

    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == {CNT_W{1'b0}});

    // A write into a full FIFO is only allowed when the head leaves the same cycle.
    assign wr_en_s = push && (!full_s || pop);
    assign rd_en_s = pop && !empty_s;

    // Storage array; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (srst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (wr_en_s && !rd_en_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (rd_en_s && !wr_en_s) begin
                count_r <= count_r - CNT_ONE;
            end
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;

    idli_fifo_chk_m u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .full  (full_s),
        .empty (empty_s)
    );

endmodule

// File: rtl/idli_uart_tx_m.sv
// -----------------------------------------------------------------------------
// idli_uart_tx_m
// UART transmitter: assembles nibble-serial writes from the core into bytes,
// buffers them and shifts them out as 8N1 frames.
//   i_sync_gck     : ungated clock. Must stay ungated so the buffer keeps
//                    draining while the core is stalled.
//   i_sync_rst_n   : asynchronous active-low reset.
//   i_uart_tx_vld  : nibble valid (lo nibble, then hi nibble next cycle).
//   i_uart_tx_data : data nibble.
//   o_uart_tx_acp  : registered; high when a whole byte slot is free.
//   o_uart_tx      : serial line, idle high, driven from a flop.
//   o_uart_tx_busy : frame on the line or bytes still buffered.
// -----------------------------------------------------------------------------
module idli_uart_tx_m
    import idli_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       i_sync_gck,
    input  logic       i_sync_rst_n,
    input  logic       i_uart_tx_vld,
    input  logic [3:0] i_uart_tx_data,
    output logic       o_uart_tx_acp,
    output logic       o_uart_tx,
    output logic       o_uart_tx_busy
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BAUD_W = 16;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // Nibble assembler.
    logic             phase_r;       // 1 = lo nibble held, slot reserved
    logic             phase_nxt_s;
    logic [3:0]       lo_nib_r;
    logic [3:0]       lo_nib_nxt_s;
    logic             lo_wr_s;
    logic             hi_wr_s;
    logic             acp_r;
    logic             acp_nxt_s;

    // FIFO interface.
    logic             push_s;
    logic             pop_s;
    logic [7:0]       push_data_s;
    logic [7:0]       head_s;
    logic [CNT_W-1:0] count_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             full_s;
    logic             empty_s;

    // Serialiser.
    uart_tx_state_t   state_r;
    uart_tx_state_t   state_nxt_s;
    logic [BAUD_W-1:0] baud_r;
    logic [BAUD_W-1:0] baud_nxt_s;
    logic [2:0]       bit_r;
    logic [2:0]       bit_nxt_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nxt_s;
    logic             tx_r;
    logic             tx_nxt_s;
    logic             baud_wrap_s;
    logic             bit_last_s;

    // ------------------------------------------------------------------
    // Nibble assembly
    // ------------------------------------------------------------------
    // The lo nibble needs a free slot; once reserved, the hi nibble is
    // always taken so the core never stalls mid-byte.
    assign lo_wr_s     = i_uart_tx_vld && !phase_r && acp_r;
    assign hi_wr_s     = i_uart_tx_vld && phase_r;
    assign push_data_s = {i_uart_tx_data, lo_nib_r};
    assign push_s      = hi_wr_s && (!full_s || pop_s);

    // Next phase and held lo nibble; a missing hi nibble just waits.
    always_comb begin
        phase_nxt_s  = phase_r;
        lo_nib_nxt_s = lo_nib_r;
        if (lo_wr_s) begin
            phase_nxt_s  = 1'b1;
            lo_nib_nxt_s = i_uart_tx_data;
        end else if (hi_wr_s) begin
            phase_nxt_s  = 1'b0;
        end else begin
            phase_nxt_s  = phase_r;
        end
    end

    // Occupancy after this edge, so acp reflects this cycle's push/pop.
    always_comb begin
        cnt_nxt_s = count_s;
        if (push_s && !pop_s) begin
            cnt_nxt_s = count_s + CNT_ONE;
        end else if (pop_s && !push_s) begin
            cnt_nxt_s = count_s - CNT_ONE;
        end else begin
            cnt_nxt_s = count_s;
        end
    end

    assign acp_nxt_s = ((32'(cnt_nxt_s) + 32'(phase_nxt_s)) < FIFO_DEPTH);

    // Nibble phase, held lo nibble and accept flag.
    always_ff @(posedge i_sync_gck or negedge i_sync_rst_n) begin
        if (!i_sync_rst_n) begin
            phase_r  <= 1'b0;
            lo_nib_r <= 4'd0;
            acp_r    <= 1'b1;
        end else begin
            phase_r  <= phase_nxt_s;
            lo_nib_r <= lo_nib_nxt_s;
            acp_r    <= acp_nxt_s;
        end
    end

    idli_fifo_m #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_sync_gck),
        .rst_n     (i_sync_rst_n),
        .srst      (1'b0),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    assign baud_wrap_s = (baud_r == BAUD_LAST);
    assign bit_last_s  = (bit_r == BIT_LAST);

    // State register.
    always_ff @(posedge i_sync_gck or negedge i_sync_rst_n) begin
        if (!i_sync_rst_n) begin
            state_r <= UART_TX_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; STOP chains straight into START for back-to-back frames.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            UART_TX_IDLE: begin
                if (!empty_s) begin
                    state_nxt_s = UART_TX_START;
                end else begin
                    state_nxt_s = UART_TX_IDLE;
                end
            end
            UART_TX_START: begin
                if (baud_wrap_s) begin
                    state_nxt_s = UART_TX_DATA;
                end else begin
                    state_nxt_s = UART_TX_START;
                end
            end
            UART_TX_DATA: begin
                if (baud_wrap_s && bit_last_s) begin
                    state_nxt_s = UART_TX_STOP;
                end else begin
                    state_nxt_s = UART_TX_DATA;
                end
            end
            UART_TX_STOP: begin
                if (baud_wrap_s && !empty_s) begin
                    state_nxt_s = UART_TX_START;
                end else if (baud_wrap_s) begin
                    state_nxt_s = UART_TX_IDLE;
                end else begin
                    state_nxt_s = UART_TX_STOP;
                end
            end
            default: begin
                state_nxt_s = UART_TX_IDLE;
            end
        endcase
    end

    // Output/datapath logic: pop, shifter, counters and next line level.
    always_comb begin
        pop_s       = 1'b0;
        shift_nxt_s = shift_r;
        baud_nxt_s  = baud_r;
        bit_nxt_s   = bit_r;
        tx_nxt_s    = 1'b1;

        pop_s = !empty_s && ((state_r == UART_TX_IDLE) ||
                             ((state_r == UART_TX_STOP) && baud_wrap_s));

        if (pop_s) begin
            shift_nxt_s = head_s;
        end else if ((state_r == UART_TX_DATA) && baud_wrap_s) begin
            shift_nxt_s = {1'b0, shift_r[7:1]};
        end else begin
            shift_nxt_s = shift_r;
        end

        // Wrapping to 0 on every advance also gives a 0 on every state entry.
        if (state_r == UART_TX_IDLE) begin
            baud_nxt_s = {BAUD_W{1'b0}};
        end else if (baud_wrap_s) begin
            baud_nxt_s = {BAUD_W{1'b0}};
        end else begin
            baud_nxt_s = baud_r + 16'd1;
        end

        // 3-bit counter naturally wraps 7->0 as DATA ends.
        if ((state_r == UART_TX_DATA) && baud_wrap_s) begin
            bit_nxt_s = bit_r + 3'd1;
        end else begin
            bit_nxt_s = bit_r;
        end

        // Line level is chosen from the state being entered so the flop
        // changes on the same edge as the state.
        case (state_nxt_s)
            UART_TX_IDLE:  tx_nxt_s = 1'b1;
            UART_TX_START: tx_nxt_s = 1'b0;
            UART_TX_DATA:  tx_nxt_s = shift_nxt_s[0];
            UART_TX_STOP:  tx_nxt_s = 1'b1;
            default:       tx_nxt_s = 1'b1;
        endcase
    end

    // Serialiser datapath registers; reset forces the line high at once.
    always_ff @(posedge i_sync_gck or negedge i_sync_rst_n) begin
        if (!i_sync_rst_n) begin
            baud_r  <= {BAUD_W{1'b0}};
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
            tx_r    <= 1'b1;
        end else begin
            baud_r  <= baud_nxt_s;
            bit_r   <= bit_nxt_s;
            shift_r <= shift_nxt_s;
            tx_r    <= tx_nxt_s;
        end
    end

    assign o_uart_tx      = tx_r;
    assign o_uart_tx_acp  = acp_r;
    assign o_uart_tx_busy = (state_r != UART_TX_IDLE) || (count_s != {CNT_W{1'b0}});

endmodule

// File: tb/tb_idli_uart_tx_m.sv
module tb_idli_uart_tx_m;

    localparam int B = 4;
    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic       vld;
    logic [3:0] data;
    logic       acp;
    logic       tx;
    logic       busy;

    int vectors    = 0;
    int miscompares = 0;

    idli_uart_tx_m #(
        .BAUD_DIV   (B),
        .FIFO_DEPTH (D)
    ) dut (
        .i_sync_gck     (clk),
        .i_sync_rst_n   (rst_n),
        .i_uart_tx_vld  (vld),
        .i_uart_tx_data (data),
        .o_uart_tx_acp  (acp),
        .o_uart_tx      (tx),
        .o_uart_tx_busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time is counted in clock edges. A frame popped at edge p occupies the
    // line for 10*B edges; bytes wait in a queue until the line is free.
    int         m_n;
    int         m_p;
    logic       m_act;
    logic [7:0] m_cur;
    logic       m_ph;
    logic [3:0] m_lo;
    logic       m_acp;
    logic [7:0] m_q[$];
    logic       exp_tx, exp_acp, exp_busy;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        else if (k >= 9) return 1'b1;
        else return b[k-1];
    endfunction

    task automatic model_outputs();
        exp_tx   = m_act ? frame_bit(m_cur, (m_n - m_p) / B) : 1'b1;
        exp_acp  = m_acp;
        exp_busy = m_act || (m_q.size() > 0);
    endtask

    task automatic model_reset();
        m_act = 1'b0; m_ph = 1'b0; m_lo = 4'h0; m_acp = 1'b1; m_p = 0;
        m_q.delete();
        model_outputs();
    endtask

    task automatic model_step();
        m_n++;
        if (m_act && (m_n == m_p + 10 * B)) m_act = 1'b0;
        if (!m_act && (m_q.size() > 0)) begin
            m_cur = m_q.pop_front();
            m_act = 1'b1;
            m_p   = m_n;
        end
        if (vld) begin
            if (m_ph) begin
                m_q.push_back({data, m_lo});
                m_ph = 1'b0;
            end else if (m_acp) begin
                m_lo = data;
                m_ph = 1'b1;
            end
        end
        m_acp = ((m_q.size() + int'(m_ph)) < D);
        model_outputs();
    endtask

    initial begin
        m_n = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("line", tx, exp_tx);
            check("acp", acp, exp_acp);
            check("busy", busy, exp_busy);
        end
    end

    // ---------------- serial receiver ----------------
    logic       rx_on = 1'b0;
    int         rx_k;
    logic [7:0] rx_sh;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rx_on = 1'b0;
            end else if (!rx_on) begin
                if (tx === 1'b0) begin
                    rx_on = 1'b1;
                    rx_k  = 0;
                end
            end else begin
                rx_k++;
                if (rx_k == B / 2) check("rx_start", tx, 0);
                if ((rx_k > B) && (rx_k < 9 * B) && ((rx_k % B) == B / 2))
                    rx_sh[rx_k / B - 1] = tx;
                if (rx_k == 9 * B + B / 2) begin
                    check("rx_stop", tx, 1);
                    rx_q.push_back(rx_sh);
                    rx_on = 1'b0;
                end
            end
        end
    end

    task automatic check_rx();
        check("rx_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < rx_q.size()) check("rx_byte", rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic nib(input logic [3:0] d);
        @(negedge clk);
        vld = 1'b1; data = d;
    endtask

    task automatic release_bus();
        @(negedge clk);
        vld = 1'b0; data = 4'h0;
    endtask

    // Drive a nibble so it is sampled at edge e.
    task automatic nib_at(input int e, input logic [3:0] d);
        int g = 0;
        while ((m_n < e - 1) && (g < 2000)) begin
            @(negedge clk);
            g++;
        end
        check("nib_at_window", m_n, e - 1);
        vld = 1'b1; data = d;
    endtask

    task automatic wait_drain();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (((busy !== 1'b0) || rx_on) && (g < 600));
        check("drain_in_time", (g < 600), 1);
        repeat (3) @(negedge clk);
    endtask

    logic log_tx[64];
    logic log_busy[64];
    int   h, p, hi1, ret_n, g;
    logic [0:9] a5_frame;

    initial begin
        rst_n = 1'b0; vld = 1'b0; data = 4'h0;
        a5_frame = 10'b0101001011;

        // Reset and idle.
        repeat (3) @(negedge clk);
        check("rst_line", tx, 1);
        check("rst_acp", acp, 1);
        check("rst_busy", busy, 0);
        #2 rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_line", tx, 1);
        check("idle_acp", acp, 1);
        check("idle_busy", busy, 0);

        // Single byte 0xA5: latency, bit timing, frame length, busy fall.
        nib(4'h5);
        nib(4'hA);
        h = m_n + 1;
        for (int i = 0; i < 46; i++) begin
            @(negedge clk);
            vld = 1'b0;
            log_tx[i]   = tx;
            log_busy[i] = busy;
        end
        check("model_latency", m_p, h + 1);
        check("a5_pre_start", log_tx[0], 1);
        for (int j = 0; j < 10; j++) begin
            check("a5_bit_first", log_tx[1 + j * B], a5_frame[j]);
            check("a5_bit_last", log_tx[1 + j * B + B - 1], a5_frame[j]);
        end
        check("a5_after_frame", log_tx[1 + 10 * B], 1);
        check("a5_busy_last", log_busy[10 * B], 1);
        check("a5_busy_fall", log_busy[1 + 10 * B], 0);
        exp_q.push_back(8'hA5);
        wait_drain();
        check_rx();

        // Five bytes back-to-back fill shifter + FIFO; sixth lo is refused.
        for (int b = 1; b <= 5; b++) begin
            nib(4'(b));
            if (b == 5) check("acp_before_5th", acp, 1);
            nib(4'h0);
            if (b == 1) hi1 = m_n + 1;
        end
        check("acp_after_5th_lo", acp, 0);
        nib(4'h6);
        release_bus();
        g = 0;
        while ((acp !== 1'b1) && (g < 300)) begin
            @(negedge clk);
            g++;
        end
        ret_n = m_n;
        check("acp_return_edge", ret_n, hi1 + 1 + 10 * B);
        nib(4'h6);
        nib(4'h0);
        release_bus();
        for (int b = 1; b <= 6; b++) exp_q.push_back(8'(b));
        wait_drain();
        check_rx();

        // Push on the same edge STOP pops the next entry.
        nib(4'h1);
        nib(4'h1);
        h = m_n + 1;
        nib(4'h2);
        nib(4'h2);
        release_bus();
        p = h + 1;
        nib_at(p + 10 * B - 1, 4'h3);
        nib_at(p + 10 * B, 4'h3);
        release_bus();
        check("coincide_pop_edge", m_p, p + 10 * B);
        check("coincide_acp", acp, 1);
        check("coincide_busy", busy, 1);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        wait_drain();
        check_rx();

        // Reset during data bit 3 of 0xC3 with 0x5A still buffered.
        nib(4'h3);
        nib(4'hC);
        h = m_n + 1;
        nib(4'hA);
        nib(4'h5);
        release_bus();
        p = h + 1;
        g = 0;
        while ((m_n < p + 4 * B + 1) && (g < 200)) begin
            @(negedge clk);
            g++;
        end
        check("pre_reset_bit3", tx, 0);
        check("pre_reset_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_line", tx, 1);
        check("async_rst_acp", acp, 1);
        check("async_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        nib(4'hF);
        nib(4'hF);
        release_bus();
        exp_q.push_back(8'hFF);
        wait_drain();
        check_rx();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/idli_uart_tx_m.md
Name: idli_uart_tx_m

Overview:
UART transmitter that sinks the core's UART TX instruction data and drives the serial TX pin.
- Core delivers each byte nibble-serially.
- Bytes are buffered in a small FIFO and serialised as 8N1 frames.
- Produces the accept signal that the sync/clock-gating block uses to stall the core while the buffer is full.
- Runs on the ungated clock. It must keep draining while the core clock is gated, otherwise the core deadlocks.

Parameters:
- BAUD_DIV, 16, clock cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4, byte entries in the TX buffer; power of two, at least 2.

Ports:
- i_sync_gck  input  1  ungated core clock.
- i_sync_rst_n  input  1  reset.
- i_uart_tx_vld  input  1  nibble valid from execute stage.
- i_uart_tx_data  input  4  data nibble; low nibble first, then high nibble.
- o_uart_tx_acp  output  1  registered; high = a full byte slot is free.
- o_uart_tx  output  1  serial line; idle high.
- o_uart_tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Reset: i_sync_rst_n, asynchronous, active-low.
  - o_uart_tx=1, o_uart_tx_acp=1, o_uart_tx_busy=0.
  - FIFO empty, FSM in IDLE, all counters 0.
- Mid-operation reset aborts any frame. The line returns high immediately; a partial frame is the receiver's problem.
- Write protocol:
  - A byte write is two consecutive cycles with i_uart_tx_vld=1: cycle 0 = bits [3:0], cycle 1 = bits [7:4].
  - A nibble-phase flop tracks lo/hi.
  - The lo nibble is accepted only when o_uart_tx_acp=1. A lo nibble with acp=0 is ignored and the phase does not advance; the sync block gates the core in that case.
  - Once a lo nibble is accepted, the slot is reserved and the hi nibble is always accepted.
  - The byte enters the FIFO at the hi-nibble edge.
  - vld low in the hi phase is a protocol error: the phase holds and the lo nibble is retained until the hi nibble arrives.
- acp:
  - Computed as (count + reserved) < FIFO_DEPTH, flopped.
  - Updated the same cycle as any push/pop, visible next cycle.
  - A pop and a push in the same cycle leave count unchanged.
- FIFO: circular buffer with wrap-around pointers and an explicit count of width $clog2(FIFO_DEPTH)+1. Overflow is impossible by construction; assert it in simulation.
- Serialiser FSM, states IDLE, START, DATA, STOP:
  - IDLE: if FIFO non-empty, pop the head into the shift register, go to START, drive 0.
  - START: hold 0 for BAUD_DIV cycles, then go to DATA.
  - DATA: drive shift[0], LSB first, BAUD_DIV cycles per bit. After 8 bits (3-bit bit counter wraps 7->0), go to STOP.
  - STOP: drive 1 for BAUD_DIV cycles. Then pop directly into START if the FIFO is non-empty, giving back-to-back frames with no idle gap. Otherwise go to IDLE.
- Baud counter:
  - Counts 0..BAUD_DIV-1 and wraps.
  - Reset to 0 on every state entry.
  - The state/bit advances on the wrap cycle.
  - Frame length is exactly 10*BAUD_DIV cycles.
- Latency: the start bit appears on o_uart_tx 2 cycles after the hi-nibble edge when idle (push cycle, then pop in IDLE, flopped output).
- o_uart_tx is driven from a flop, so it is glitch-free.
- o_uart_tx_busy = (state != IDLE) || (count != 0), combinational from flops.

Decomposition:
- idli_pkg gains:
  - uart_tx_state_t enum {UART_TX_IDLE, UART_TX_START, UART_TX_DATA, UART_TX_STOP}.
  - localparam UART_FRAME_BITS=10.
- Natural sub-module: idli_fifo_m, a generic synchronous FIFO parameterised on WIDTH and DEPTH with push/pop/count/full/empty. It is reusable for the future RX path.
- The serialiser FSM and nibble assembler stay in idli_uart_tx_m.

Test Plan:
- Reset then idle 100 cycles -> o_uart_tx=1, acp=1, busy=0 throughout; async reset asserted mid-cycle takes effect immediately.
- BAUD_DIV=4, write nibbles 0x5 then 0xA (byte 0xA5) -> line sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; start bit 2 cycles after the hi nibble; 40-cycle frame; busy falls the cycle after the stop bit.
- FIFO_DEPTH=4, BAUD_DIV=8, write 5 bytes 0x01..0x05 back-to-back:
  - acp drops the cycle after the 5th slot would be needed (4 buffered plus 1 in the shifter allows all 5; retry with 6 bytes).
  - acp=0 holds until the first pop, then returns to 1.
  - Frames are back-to-back with no gap.
- Write a lo nibble with acp=0 -> ignored, phase stays lo; re-present after acp=1 -> byte accepted intact.
- Push a byte on the exact cycle STOP pops the next entry -> count unchanged, acp unchanged, no byte lost or duplicated (compare the serial stream against a scoreboard).
- Assert reset during DATA bit 3 -> line high next edge, FIFO empty, FSM IDLE; a subsequent write of 0xFF transmits a correct frame.
